// File: rtl/click_decoder.sv
// Click burst decoder: groups debounced press pulses into single/double/triple click events.
// Optional post-event lockout is enabled by defining CLICK_HOLDOFF_EN.
module click_decoder #(
  parameter int GAP_CYCLES     = 25_000_000,
  parameter int HOLDOFF_CYCLES = 5_000_000,
  parameter int MAX_CLICKS     = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Press,
  output logic       Single,
  output logic       Double,
  output logic       Triple,
  output logic       Busy,
  output logic [1:0] Clicks
);

  // state    | meaning
  // IDLE     | waiting for the first press of a burst
  // COLLECT  | counting presses, gap timer running
  // EMIT     | one-cycle event pulse for the finished burst
  // HOLDOFF  | post-event lockout, presses discarded (CLICK_HOLDOFF_EN only)

  if (GAP_CYCLES < 2 || GAP_CYCLES > 33554431 ||
      HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 33554431 || MAX_CLICKS != 3) begin : g_param_check
    $error("click_decoder: illegal parameter value");
  end

  localparam logic [24:0] GAP_LAST   = 25'(GAP_CYCLES - 1);
  localparam logic [1:0]  LAST_CLICK = 2'(MAX_CLICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
`ifdef CLICK_HOLDOFF_EN
    , HOLDOFF
`endif
  } state_t;

  state_t      state;
  logic [24:0] gap_timer;

`ifdef CLICK_HOLDOFF_EN
  localparam logic [24:0] HOLD_LAST = 25'(HOLDOFF_CYCLES - 1);
  logic [24:0] hold_cnt;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      gap_timer <= '0;
      Single    <= 1'b0;
      Double    <= 1'b0;
      Triple    <= 1'b0;
      Busy      <= 1'b0;
      Clicks    <= 2'd0;
`ifdef CLICK_HOLDOFF_EN
      hold_cnt  <= '0;
`endif
    end else begin
      Single <= 1'b0;
      Double <= 1'b0;
      Triple <= 1'b0;
      case (state)
        IDLE: begin
          if (Press) begin
            Clicks    <= 2'd1;
            gap_timer <= '0;
            Busy      <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          // A press on the timeout cycle wins: it restarts the gap instead of ending the burst.
          if (Press) begin
            Clicks    <= Clicks + 2'd1;
            gap_timer <= '0;
            if (Clicks == LAST_CLICK) begin
              Triple <= 1'b1;
              state  <= EMIT;
            end
          end else if (gap_timer == GAP_LAST) begin
            gap_timer <= '0;
            Single    <= (Clicks == 2'd1);
            Double    <= (Clicks == 2'd2);
            state     <= EMIT;
          end else begin
            gap_timer <= gap_timer + 25'd1;
          end
        end
        EMIT: begin
          Clicks <= 2'd0;
`ifdef CLICK_HOLDOFF_EN
          hold_cnt <= HOLD_LAST;
          state    <= HOLDOFF;
`else
          Busy  <= 1'b0;
          state <= IDLE;
`endif
        end
`ifdef CLICK_HOLDOFF_EN
        HOLDOFF: begin
          if (hold_cnt == 25'd0) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 25'd1;
          end
        end
`endif
        default: begin
          Busy   <= 1'b0;
          Clicks <= 2'd0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder (GAP_CYCLES=20, HOLDOFF_CYCLES=10) with an event scoreboard.
// Cycle k is the interval after the k-th sampled edge; Press driven in cycle k is sampled at its end.
module tb_click_decoder;
  localparam int GAP = 20;
  localparam int HOLD = 10;
`ifdef CLICK_HOLDOFF_EN
  localparam logic HO = 1'b1;
`else
  localparam logic HO = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Press = 1'b0;
  logic       Single, Double, Triple, Busy;
  logic [1:0] Clicks;

  click_decoder #(.GAP_CYCLES(GAP), .HOLDOFF_CYCLES(HOLD), .MAX_CLICKS(3)) dut (
    .Clk(Clk), .Reset(Reset), .Press(Press),
    .Single(Single), .Double(Double), .Triple(Triple),
    .Busy(Busy), .Clicks(Clicks)
  );

  always #5 Clk = ~Clk;

  typedef struct { int c; logic [2:0] k; } ev_t;               // k = {Triple,Double,Single}
  typedef struct { int c; logic busy; logic [1:0] clicks; } st_t;

  ev_t ev_q[$];
  st_t st_q[$];
  int  press_q[$];
  int  cyc;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    logic [2:0] pulses;
    ev_t e;
    st_t s;
    pulses = {Triple, Double, Single};
    chk("pulse_exclusive", int'($countones(pulses) <= 1), 1);
    if (pulses != 3'b000 || (ev_q.size() != 0 && ev_q[0].c == cyc)) begin
      if (ev_q.size() == 0) begin
        chk("unexpected_pulse", int'(pulses), 0);
      end else begin
        e = ev_q.pop_front();
        chk("event_kind", int'(pulses), int'(e.k));
        chk("event_cycle", cyc, e.c);
      end
    end
    while (st_q.size() != 0 && st_q[0].c == cyc) begin
      s = st_q.pop_front();
      chk("busy", int'(Busy), int'(s.busy));
      chk("clicks", int'(Clicks), int'(s.clicks));
    end
  endtask

  task automatic begin_test();
    @(negedge Clk);
    Reset = 1'b1;
    Press = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    cyc = 0;
    chk("reset_busy", int'(Busy), 0);
    chk("reset_clicks", int'(Clicks), 0);
    chk("reset_pulses", int'({Triple, Double, Single}), 0);
    ev_q.delete();
    st_q.delete();
    press_q.delete();
  endtask

  task automatic run(input int ncycles, input int rst_cyc);
    bit p;
    for (int i = 0; i < ncycles; i++) begin
      @(negedge Clk);
      cyc++;
      check_cycle();
      p = 1'b0;
      foreach (press_q[j]) if (press_q[j] == cyc) p = 1'b1;
      Press = p;
      Reset = (cyc == rst_cyc);
    end
    Press = 1'b0;
    Reset = 1'b0;
    chk("missed_events", ev_q.size(), 0);
    chk("missed_states", st_q.size(), 0);
  endtask

  initial begin
    // single click, timeout latency N+GAP+1
    begin_test();
    press_q = '{10};
    ev_q.push_back('{31, 3'b001});
    st_q = '{'{10, 1'b0, 2'd0}, '{11, 1'b1, 2'd1}, '{30, 1'b1, 2'd1},
             '{31, 1'b1, 2'd1}, '{32, HO, 2'd0}};
    run(50, -1);

    // double click
    begin_test();
    press_q = '{10, 25};
    ev_q.push_back('{46, 3'b010});
    st_q = '{'{25, 1'b1, 2'd1}, '{26, 1'b1, 2'd2}, '{46, 1'b1, 2'd2}, '{47, HO, 2'd0}};
    run(65, -1);

    // triple click ends the burst without waiting for the gap
    begin_test();
    press_q = '{10, 15, 20};
    ev_q.push_back('{21, 3'b100});
    st_q = '{'{16, 1'b1, 2'd2}, '{21, 1'b1, 2'd3}, '{22, HO, 2'd0}};
    run(45, -1);

    // press exactly on timer==GAP-1 counts as a click
    begin_test();
    press_q = '{10, 30};
    ev_q.push_back('{51, 3'b010});
    st_q = '{'{30, 1'b1, 2'd1}, '{31, 1'b1, 2'd2}};
    run(70, -1);

    // press during EMIT is ignored
    begin_test();
    press_q = '{10, 31};
    ev_q.push_back('{31, 3'b001});
    st_q = '{'{32, HO, 2'd0}, '{33, HO, 2'd0}};
    run(70, -1);

`ifdef CLICK_HOLDOFF_EN
    // holdoff: press discarded during lockout, accepted on first IDLE cycle
    begin_test();
    press_q = '{10, 35, 42};
    ev_q.push_back('{31, 3'b001});
    ev_q.push_back('{63, 3'b001});
    st_q = '{'{32, 1'b1, 2'd0}, '{36, 1'b1, 2'd0}, '{41, 1'b1, 2'd0},
             '{42, 1'b0, 2'd0}, '{43, 1'b1, 2'd1}};
    run(85, -1);
`else
    // press on the first cycle after EMIT starts a new burst
    begin_test();
    press_q = '{10, 32};
    ev_q.push_back('{31, 3'b001});
    ev_q.push_back('{53, 3'b001});
    st_q = '{'{32, 1'b0, 2'd0}, '{33, 1'b1, 2'd1}, '{54, 1'b0, 2'd0}};
    run(70, -1);
`endif

    // reset mid-burst discards it; press under reset ignored
    begin_test();
    press_q = '{10, 20};
    st_q = '{'{20, 1'b1, 2'd1}, '{21, 1'b0, 2'd0}, '{31, 1'b0, 2'd0}, '{45, 1'b0, 2'd0}};
    run(60, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
